serial_adder_ctrl: RTL and testbench

Bit-serial add/subtract sequencer that drives a single 1-bit full-adder cell over a WIDTH-bit operand pair, one bit per clock, LSB first. It latches operands on a start handshake, runs WIDTH bit-steps through the cell with a registered carry, and presents sum, carry-out and signed overflow with a one-cycle done pulse. It is the area-minimal alternative to the ripple adder32 datapath and sits between the register file and the ALU result mux.

---
 rtl/serial_adder_ctrl.sv | 106 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract: one full-adder cell stepped over WIDTH bits, LSB first.
// Latency: WIDTH+1 cycles from start request to the one-cycle done pulse.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted.
module serial_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] F,
    output logic             Cout,
    output logic             OF
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic           carry;
    logic [CW-1:0]  cnt;
    logic           load, step, last;
    logic           cell_x, cell_y, cell_f, cell_co;

    // The only adder logic on the datapath.
    assign cell_x  = a_sr[0];
    assign cell_y  = b_sr[0];
    assign cell_f  = cell_x ^ cell_y ^ carry;
    assign cell_co = ((cell_x ^ cell_y) & carry) | (cell_x & cell_y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            F     <= '0;
            Cout  <= 1'b0;
            OF    <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= last;
            if (load) begin
                // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
                a_sr  <= A;
                b_sr  <= sub ? ~B : B;
                carry <= sub;
                cnt   <= '0;
                F     <= '0;
                Cout  <= 1'b0;
                OF    <= 1'b0;
            end else if (step) begin
                carry <= cell_co;
                F     <= {cell_f, F[WIDTH-1:1]};
                a_sr  <= a_sr >> 1;
                b_sr  <= b_sr >> 1;
                if (last) begin
                    cnt  <= '0;
                    Cout <= cell_co;
                    OF   <= carry ^ cell_co;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed cases plus random ops, scoreboard-checked
// against an arithmetic reference model.
module tb_serial_adder_ctrl;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             busy, done, Cout, OF;
    logic [WIDTH-1:0] F;

    int tests = 0;
    int fails = 0;
    logic [WIDTH+1:0] exp_q[$];

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(A), .B(B),
        .busy(busy), .done(done), .F(F), .Cout(Cout), .OF(OF)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {F, Cout, OF} from plain two's-complement arithmetic.
    function automatic logic [WIDTH+1:0] ref_model(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic s);
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] f;
        logic             c, o;
        if (s) begin
            f = a - b;
            c = (a >= b);
            o = (a[WIDTH-1] != b[WIDTH-1]) && (f[WIDTH-1] != a[WIDTH-1]);
        end else begin
            r = {1'b0, a} + {1'b0, b};
            f = r[WIDTH-1:0];
            c = r[WIDTH];
            o = (a[WIDTH-1] == b[WIDTH-1]) && (f[WIDTH-1] != a[WIDTH-1]);
        end
        return {f, c, o};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [WIDTH+1:0] e;
        if (rst_n && done) begin
            chk("done_busy_exclusive", {63'd0, busy}, 64'd0);
            if (exp_q.size() == 0) begin
                chk("spurious_done", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("F", 64'(F), 64'(e[WIDTH+1:2]));
                chk("Cout", {63'd0, Cout}, {63'd0, e[1]});
                chk("OF", {63'd0, OF}, {63'd0, e[0]});
            end
        end
    end

    // Called just after a rising edge; start is sampled at the following edge.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        int w = 0;
        while (busy && w < 200) begin
            @(posedge clk); #1; w++;
        end
        if (busy) chk("issue_wait_timeout", {63'd0, busy}, 64'd0);
        A = a; B = b; sub = s; start = 1'b1;
        exp_q.push_back(ref_model(a, b, s));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s, input bit ign);
        int cyc = 0;
        int bcnt = 0;
        issue(a, b, s);
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
        if (busy) bcnt = 1;
        while (!done && cyc < 100) begin
            start = ign && (cyc == 5 || cyc == 20);
            A = $urandom; B = $urandom; sub = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
            if (busy) bcnt++;
        end
        start = 1'b0;
        chk("latency", 64'(cyc + 1), 64'(WIDTH + 1));
        chk("busy_cycles", 64'(bcnt), 64'(WIDTH));
    endtask

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(WIDTH-1){1'b0}}};
            3: return {1'b0, {(WIDTH-1){1'b1}}};
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        #12;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_F", 64'(F), 64'd0);
        chk("rst_Cout_OF", {62'd0, Cout, OF}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
        chk("b2b_in_done_cycle", {63'd0, done}, 64'd1);
        run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);

        // Asynchronous reset mid-run aborts without a done pulse.
        issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
        repeat (10) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_F", 64'(F), 64'd0);
        chk("abort_Cout_OF", {62'd0, Cout, OF}, 64'd0);
        exp_q.delete();
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; end
        run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            run_op(pick(), pick(), 1'($urandom_range(0, 1)), 1'b0);
        end
        repeat (3) begin @(posedge clk); #1; end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
